// File: rtl/teletext_fetch_ctrl_pkg.sv
// Shared constants, types and address helper for the MODE 7 teletext fetch controller.
package teletext_fetch_ctrl_pkg;

    localparam logic [6:0] TTX_SPACE = 7'h20;

    localparam int unsigned PH_SAMPLE  = 0;
    localparam int unsigned PH_FETCH   = 1;
    localparam int unsigned PH_CAPTURE = 2;

    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_GRANT,
        CPU_DONE
    } cpu_state_t;

    typedef struct packed {
        logic dispen;
        logic hsync;
        logic vsync;
    } crtc_ctl_t;

    // Page base plus 10-bit CRTC offset, wrapping within the 32K RAM.
    function automatic logic [14:0] ttx_fetch_addr(input logic [14:0] base, input logic [9:0] ma);
        return base + {5'd0, ma};
    endfunction

endpackage

// File: rtl/teletext_fetch_ctrl_if.sv
// CPU request/acknowledge and shared video RAM port of the teletext fetch controller.
interface teletext_fetch_ctrl_if;

    logic        CPU_REQ;
    logic        CPU_WE;
    logic [14:0] CPU_ADDR;
    logic [7:0]  CPU_WDATA;
    logic        CPU_ACK;
    logic [7:0]  CPU_RDATA;
    logic [14:0] RAM_ADDR;
    logic        RAM_WE;
    logic [7:0]  RAM_WDATA;
    logic [7:0]  RAM_RDATA;

    // Controller side.
    modport slave (
        input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, RAM_RDATA,
        output CPU_ACK, CPU_RDATA, RAM_ADDR, RAM_WE, RAM_WDATA
    );

    // CPU requester plus RAM device side.
    modport master (
        output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, RAM_RDATA,
        input  CPU_ACK, CPU_RDATA, RAM_ADDR, RAM_WE, RAM_WDATA
    );

endinterface

// File: rtl/teletext_fetch_ctrl_clken.sv
// Dot/character clock-enable divider: SA_T6 on five ticks, SA_F1 on the sixth, plus slot phase.
module teletext_clken #(
    parameter  int unsigned CLK_DIV_T6 = 4,
    localparam int unsigned PHW        = $clog2(6 * CLK_DIV_T6)
) (
    input  logic           CLK,
    input  logic           nRESET,
    output logic           SA_F1,
    output logic           SA_T6,
    output logic [PHW-1:0] PH
);

    localparam int unsigned DW = (CLK_DIV_T6 > 1) ? $clog2(CLK_DIV_T6) : 1;

    logic [DW-1:0] dcnt;
    logic [2:0]    tcnt;
    logic          tick;

    assign tick  = (dcnt == DW'(CLK_DIV_T6 - 1));
    assign SA_F1 = tick && (tcnt == 3'd5);
    assign SA_T6 = tick && (tcnt != 3'd5);

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            dcnt <= '0;
            tcnt <= '0;
            PH   <= '0;
        end else begin
            if (tick) begin
                dcnt <= '0;
                tcnt <= (tcnt == 3'd5) ? 3'd0 : tcnt + 3'd1;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
            PH <= SA_F1 ? '0 : PH + PHW'(1);
        end
    end

endmodule

// File: rtl/teletext_fetch_ctrl.sv
// MODE 7 teletext character fetch, sync alignment and CPU/teletext arbitration of the shared RAM port.
module teletext_fetch_ctrl
    import teletext_fetch_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV_T6 = 4,
    parameter logic [14:0] TTX_BASE   = 15'h7C00,
    parameter int unsigned SYNC_DELAY = 2
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    input  logic [13:0]           CRTC_MA,
    input  logic                  CRTC_DISPEN,
    input  logic                  CRTC_HSYNC,
    input  logic                  CRTC_VSYNC,
    teletext_fetch_ctrl_if.slave  bus,
    output logic                  SA_F1,
    output logic                  SA_T6,
    output logic [6:0]            DATABUS,
    output logic                  LOSE,
    output logic                  HSYNC,
    output logic                  VSYNC
);

    localparam int unsigned    PHW  = $clog2(6 * CLK_DIV_T6);
    localparam logic [PHW-1:0] PH_S = PHW'(PH_SAMPLE);
    localparam logic [PHW-1:0] PH_C = PHW'(PH_CAPTURE);

    logic [PHW-1:0] ph;
    crtc_ctl_t      slot_ctl;
    crtc_ctl_t      dly [SYNC_DELAY];
    logic [6:0]     code_hold;
    cpu_state_t     cpu_state;
    logic           fetch_next;
    logic           grant;
    logic           unused_ma_hi;

    teletext_clken #(.CLK_DIV_T6(CLK_DIV_T6)) u_clken (
        .CLK    (CLK),
        .nRESET (nRESET),
        .SA_F1  (SA_F1),
        .SA_T6  (SA_T6),
        .PH     (ph)
    );

    assign unused_ma_hi = ^CRTC_MA[13:10];

    // The RAM port is registered, so the fetch slot is claimed one cycle early (at the sample
    // phase) from the live CRTC inputs, which are stable for the whole character slot.
    assign fetch_next = (ph == PH_S) && CRTC_DISPEN;
    assign grant      = (cpu_state == CPU_IDLE) && bus.CPU_REQ && !bus.CPU_ACK && !fetch_next;

    assign LOSE  = dly[SYNC_DELAY-1].dispen;
    assign HSYNC = dly[SYNC_DELAY-1].hsync;
    assign VSYNC = dly[SYNC_DELAY-1].vsync;

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            slot_ctl  <= '0;
            code_hold <= TTX_SPACE;
            DATABUS   <= TTX_SPACE;
            for (int unsigned i = 0; i < SYNC_DELAY; i++) dly[i] <= '0;
        end else begin
            if (ph == PH_S)
                slot_ctl <= '{dispen: CRTC_DISPEN, hsync: CRTC_HSYNC, vsync: CRTC_VSYNC};
            if (ph == PH_C)
                code_hold <= slot_ctl.dispen ? bus.RAM_RDATA[6:0] : TTX_SPACE;
            if (SA_F1) begin
                DATABUS <= code_hold;
                dly[0]  <= slot_ctl;
                for (int unsigned i = 1; i < SYNC_DELAY; i++) dly[i] <= dly[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            cpu_state     <= CPU_IDLE;
            bus.CPU_ACK   <= 1'b0;
            bus.CPU_RDATA <= '0;
            bus.RAM_ADDR  <= '0;
            bus.RAM_WE    <= 1'b0;
            bus.RAM_WDATA <= '0;
        end else begin
            bus.CPU_ACK <= 1'b0;
            bus.RAM_WE  <= 1'b0;
            case (cpu_state)
                CPU_IDLE: begin
                    if (grant) begin
                        cpu_state     <= CPU_GRANT;
                        bus.RAM_ADDR  <= bus.CPU_ADDR;
                        bus.RAM_WE    <= bus.CPU_WE;
                        bus.RAM_WDATA <= bus.CPU_WDATA;
                    end
                end
                CPU_GRANT: cpu_state <= CPU_DONE;
                CPU_DONE: begin
                    cpu_state     <= CPU_IDLE;
                    bus.CPU_RDATA <= bus.RAM_RDATA;
                    bus.CPU_ACK   <= 1'b1;
                end
                default: cpu_state <= CPU_IDLE;
            endcase
            if (fetch_next)
                bus.RAM_ADDR <= ttx_fetch_addr(TTX_BASE, CRTC_MA[9:0]);
        end
    end

endmodule

// File: tb/tb_teletext_fetch_ctrl.sv
// Directed bench for teletext_fetch_ctrl: enable timing, fetch/blank slots, CPU arbitration, reset abort.
module tb_teletext_fetch_ctrl;

    localparam int P = 24;

    logic        CLK;
    logic        nRESET;
    logic [13:0] CRTC_MA;
    logic        CRTC_DISPEN;
    logic        CRTC_HSYNC;
    logic        CRTC_VSYNC;
    logic        SA_F1;
    logic        SA_T6;
    logic [6:0]  DATABUS;
    logic        LOSE;
    logic        HSYNC;
    logic        VSYNC;

    teletext_fetch_ctrl_if bus();

    teletext_fetch_ctrl #(
        .CLK_DIV_T6 (4),
        .TTX_BASE   (15'h7C00),
        .SYNC_DELAY (2)
    ) dut (
        .CLK         (CLK),
        .nRESET      (nRESET),
        .CRTC_MA     (CRTC_MA),
        .CRTC_DISPEN (CRTC_DISPEN),
        .CRTC_HSYNC  (CRTC_HSYNC),
        .CRTC_VSYNC  (CRTC_VSYNC),
        .bus         (bus),
        .SA_F1       (SA_F1),
        .SA_T6       (SA_T6),
        .DATABUS     (DATABUS),
        .LOSE        (LOSE),
        .HSYNC       (HSYNC),
        .VSYNC       (VSYNC)
    );

    logic [7:0] mem [0:32767];
    int         tcyc;
    int         n_tests;
    int         n_fail;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous RAM, one cycle read latency.
    always @(posedge CLK) begin
        if (bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_WDATA;
        bus.RAM_RDATA <= mem[bus.RAM_ADDR];
    end

    // Cycle index since the last reset cycle; phase = tcyc % P.
    always @(posedge CLK) begin
        if (!nRESET) tcyc <= 0;
        else         tcyc <= tcyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_ph(input int p);
        do @(negedge CLK); while ((tcyc % P) != p);
    endtask

    task automatic set_slot(input logic d, input logic h, input logic v, input logic [13:0] ma);
        CRTC_DISPEN = d;
        CRTC_HSYNC  = h;
        CRTC_VSYNC  = v;
        CRTC_MA     = ma;
    endtask

    task automatic cpu_req(input logic we, input logic [14:0] addr, input logic [7:0] wdata);
        bus.CPU_REQ   = 1'b1;
        bus.CPU_WE    = we;
        bus.CPU_ADDR  = addr;
        bus.CPU_WDATA = wdata;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ack"},     64'(bus.CPU_ACK),   64'h0);
        check({tag, "_rdata"},   64'(bus.CPU_RDATA), 64'h0);
        check({tag, "_ramaddr"}, 64'(bus.RAM_ADDR),  64'h0);
        check({tag, "_ramwe"},   64'(bus.RAM_WE),    64'h0);
        check({tag, "_wdata"},   64'(bus.RAM_WDATA), 64'h0);
        check({tag, "_f1t6"},    64'({SA_F1, SA_T6}), 64'h0);
        check({tag, "_databus"}, 64'(DATABUS),       64'h20);
        check({tag, "_syncs"},   64'({LOSE, HSYNC, VSYNC}), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] obs_t6, obs_f1, exp_t6, exp_f1;
        int          ack_at;

        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        mem[15'h7C05] = 8'h41;
        mem[15'h1234] = 8'h5A;

        nRESET        = 1'b0;
        set_slot(1'b0, 1'b0, 1'b0, 14'h0000);
        bus.CPU_REQ   = 1'b0;
        bus.CPU_WE    = 1'b0;
        bus.CPU_ADDR  = '0;
        bus.CPU_WDATA = '0;

        repeat (3) @(negedge CLK);
        check_reset_state("reset");

        // Enable timing over two character slots.
        nRESET = 1'b1;
        for (int i = 0; i < 48; i++) begin
            if (i > 0) @(negedge CLK);
            obs_t6[i] = SA_T6;
            obs_f1[i] = SA_F1;
            exp_t6[i] = ((i % 4) == 3) && (((i / 4) % 6) != 5);
            exp_f1[i] = ((i % 24) == 23);
        end
        check("t6_pattern", 64'(obs_t6), 64'(exp_t6));
        check("f1_pattern", 64'(obs_f1), 64'(exp_f1));
        check("t6_f1_overlap", 64'(obs_t6 & obs_f1), 64'h0);

        // Displayed slot fetching page offset 5.
        set_slot(1'b1, 1'b1, 1'b0, 14'h0005);
        wait_ph(1);
        check("fetch_addr", 64'(bus.RAM_ADDR), 64'h7C05);
        check("fetch_we",   64'(bus.RAM_WE),   64'h0);

        // Blanked slot: no fetch even though MA changes.
        wait_ph(23);
        set_slot(1'b0, 1'b0, 1'b1, 14'h0010);
        wait_ph(0);
        check("databus_41",  64'(DATABUS), 64'h41);
        check("lose_early",  64'({LOSE, HSYNC, VSYNC}), 64'h0);
        wait_ph(1);
        check("nofetch_addr", 64'(bus.RAM_ADDR), 64'h7C05);
        check("nofetch_we",   64'(bus.RAM_WE),   64'h0);

        wait_ph(23);
        set_slot(1'b0, 1'b0, 1'b0, 14'h0000);
        wait_ph(0);
        check("sync_disp_slot", 64'({LOSE, HSYNC, VSYNC}), 64'h6);
        check("databus_blank",  64'(DATABUS), 64'h20);

        // CPU read colliding with the fetch slot; MA upper bits must be ignored.
        wait_ph(23);
        set_slot(1'b1, 1'b0, 1'b0, 14'h3C05);
        wait_ph(0);
        check("sync_blank_slot", 64'({LOSE, HSYNC, VSYNC}), 64'h1);
        check("databus_blank2",  64'(DATABUS), 64'h20);
        cpu_req(1'b0, 15'h1234, 8'h00);
        wait_ph(1);
        check("collide_fetch_addr", 64'(bus.RAM_ADDR), 64'h7C05);
        check("collide_ack_ph1",    64'(bus.CPU_ACK),  64'h0);
        wait_ph(2);
        check("cpu_grant_addr", 64'(bus.RAM_ADDR), 64'h1234);
        check("cpu_grant_we",   64'(bus.RAM_WE),   64'h0);
        wait_ph(3);
        check("cpu_ack_ph3", 64'(bus.CPU_ACK), 64'h0);
        wait_ph(4);
        check("cpu_ack_ph4", 64'(bus.CPU_ACK),   64'h1);
        check("cpu_rdata",   64'(bus.CPU_RDATA), 64'h5A);
        bus.CPU_REQ = 1'b0;
        wait_ph(5);
        check("cpu_ack_ph5", 64'(bus.CPU_ACK), 64'h0);

        // CPU write granted at ph0 lands before the ph1 fetch.
        wait_ph(23);
        set_slot(1'b1, 1'b0, 1'b0, 14'h0005);
        cpu_req(1'b1, 15'h7C05, 8'hC3);
        wait_ph(0);
        check("databus_wrapcheck", 64'(DATABUS), 64'h41);
        check("wr_we_ph0",    64'(bus.RAM_WE),    64'h1);
        check("wr_addr_ph0",  64'(bus.RAM_ADDR),  64'h7C05);
        check("wr_wdata_ph0", 64'(bus.RAM_WDATA), 64'hC3);
        wait_ph(1);
        check("wr_we_ph1",   64'(bus.RAM_WE),   64'h0);
        check("wr_addr_ph1", 64'(bus.RAM_ADDR), 64'h7C05);
        check("wr_ack_ph1",  64'(bus.CPU_ACK),  64'h0);
        wait_ph(2);
        check("wr_ack_ph2", 64'(bus.CPU_ACK), 64'h1);
        bus.CPU_REQ = 1'b0;
        bus.CPU_WE  = 1'b0;

        wait_ph(23);
        set_slot(1'b0, 1'b0, 1'b0, 14'h0000);
        wait_ph(0);
        check("databus_written", 64'(DATABUS), 64'h43);
        check("lose_written",    64'(LOSE),    64'h1);

        // Reset while the CPU access is granted.
        wait_ph(4);
        cpu_req(1'b0, 15'h1234, 8'h00);
        wait_ph(5);
        check("abort_grant_addr", 64'(bus.RAM_ADDR), 64'h1234);
        nRESET = 1'b0;
        @(negedge CLK);
        check_reset_state("abort");
        nRESET = 1'b1;
        ack_at = 999;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge CLK);
            if (bus.CPU_ACK) begin
                ack_at = tcyc;
                break;
            end
        end
        check("rearb_ack_cycle", 64'(ack_at), 64'd3);
        check("rearb_rdata", 64'(bus.CPU_RDATA), 64'h5A);
        bus.CPU_REQ = 1'b0;
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
